// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding and ASCII code points.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [7:0] ASCII_CR         = 8'h0D;
   localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
   localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

   // Pointer width for n requesters, never narrower than one bit.
   function automatic int ptr_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_hex_to_ascii.sv
// Converts one hex nibble into its uppercase ASCII character; the inverse of the
// ASCII-to-hex decoder used on the receive side.
module hex_to_ascii (
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);
   import uart_tx_arbiter_pkg::*;

   // Digits map onto '0'..'9', letters onto 'A'..'F'.
   always_comb begin
      if (i_nibble < 4'd10) begin
         o_ascii = ASCII_DIGIT_BASE + {4'h0, i_nibble};
      end else begin
         o_ascii = ASCII_ALPHA_BASE + {4'h0, i_nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several requesters share one UART transmitter,
// sending each payload as uppercase hex digits, optionally followed by a CR.
module uart_tx_arbiter #(
   parameter int REQ_COUNT   = 2,
   parameter int DIGIT_COUNT = 4,
   parameter int APPEND_CR   = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [REQ_COUNT-1:0]                 req,
   input  logic [REQ_COUNT*DIGIT_COUNT*4-1:0]   data_in,
   output logic [REQ_COUNT-1:0]                 grant,
   output logic [REQ_COUNT-1:0]                 done,
   output logic                                 busy,
   output logic                                 tx_valid,
   output logic [7:0]                           tx_data,
   input  logic                                 tx_ready
);
   import uart_tx_arbiter_pkg::*;

   localparam int PW    = DIGIT_COUNT * 4;
   localparam int PTR_W = ptr_width(REQ_COUNT);
   localparam int CNT_W = $clog2(DIGIT_COUNT + APPEND_CR + 1);
   localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DIGIT_COUNT + APPEND_CR - 1);
   localparam logic [PTR_W-1:0]     LAST_REQ = PTR_W'(REQ_COUNT - 1);
   localparam logic [REQ_COUNT-1:0] GRANT_0  = {{(REQ_COUNT-1){1'b0}}, 1'b1};

   logic [1:0]           r_state;
   logic [REQ_COUNT-1:0] r_grant;
   logic [REQ_COUNT-1:0] r_done;
   logic                 r_tx_valid;
   logic [7:0]           r_tx_data;
   logic [CNT_W-1:0]     r_char_idx;
   logic [PTR_W-1:0]     r_rr_ptr;
   logic [PTR_W-1:0]     r_owner;
   logic [PW-1:0]        r_payload;

   logic                 w_found;
   logic [PTR_W-1:0]     w_sel;
   logic [PTR_W:0]       w_cand;
   logic [PW-1:0]        w_sel_data;
   logic [PW-1:0]        w_src_payload;
   logic [CNT_W-1:0]     w_src_idx;
   logic [3:0]           w_nibble;
   logic [7:0]           w_hex_char;
   logic [7:0]           w_char;
   logic [PTR_W-1:0]     w_next_ptr;

   // Round-robin search: first asserted request at or above rr_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_cand >= (PTR_W+1)'(REQ_COUNT)) begin
            w_cand = w_cand - (PTR_W+1)'(REQ_COUNT);
         end else begin
            w_cand = w_cand;
         end
         if (!w_found && req[w_cand[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_cand[PTR_W-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

   // Payload of the winning requester.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (w_sel == PTR_W'(i)) begin
            w_sel_data = data_in[i*PW +: PW];
         end else begin
            w_sel_data = w_sel_data;
         end
      end
   end

   // The byte register is loaded one step ahead: at grant it takes character 0 of the
   // incoming payload, on each accepted transfer it takes the following character.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_src_payload = w_sel_data;
         w_src_idx     = '0;
      end else begin
         w_src_payload = r_payload;
         w_src_idx     = r_char_idx + CNT_W'(1);
      end
   end

   // Most-significant nibble goes out first.
   always_comb begin
      w_nibble = 4'h0;
      for (int d = 0; d < DIGIT_COUNT; d++) begin
         if (w_src_idx == CNT_W'(d)) begin
            w_nibble = w_src_payload[(DIGIT_COUNT-1-d)*4 +: 4];
         end else begin
            w_nibble = w_nibble;
         end
      end
   end

   hex_to_ascii u_hex_to_ascii (
      .i_nibble (w_nibble),
      .o_ascii  (w_hex_char)
   );

   // Character after the last digit is the optional carriage return.
   always_comb begin
      if ((APPEND_CR != 0) && (w_src_idx == CNT_W'(DIGIT_COUNT))) begin
         w_char = ASCII_CR;
      end else begin
         w_char = w_hex_char;
      end
   end

   // Round-robin pointer moves just past the requester that finished.
   always_comb begin
      if (r_owner == LAST_REQ) begin
         w_next_ptr = '0;
      end else begin
         w_next_ptr = r_owner + PTR_W'(1);
      end
   end

   // Message FSM with all output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_done     <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'h00;
         r_char_idx <= '0;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_payload  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= '0;
               if (w_found) begin
                  r_state    <= ST_SEND;
                  r_grant    <= GRANT_0 << w_sel;
                  r_owner    <= w_sel;
                  r_payload  <= w_sel_data;
                  r_char_idx <= '0;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_char;
               end else begin
                  r_grant    <= '0;
                  r_tx_valid <= 1'b0;
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (r_char_idx == LAST_IDX) begin
                     r_state    <= ST_DONE;
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= 8'h00;
                     r_done     <= r_grant;
                     r_rr_ptr   <= w_next_ptr;
                  end else begin
                     r_char_idx <= r_char_idx + CNT_W'(1);
                     r_tx_data  <= w_char;
                  end
               end else begin
                  r_state <= ST_SEND;
               end
            end
            ST_DONE: begin
               r_state    <= ST_IDLE;
               r_grant    <= '0;
               r_done     <= '0;
               r_char_idx <= '0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_grant    <= '0;
               r_done     <= '0;
               r_tx_valid <= 1'b0;
               r_tx_data  <= 8'h00;
               r_char_idx <= '0;
            end
         endcase
      end
   end

   assign grant    = r_grant;
   assign done     = r_done;
   assign tx_valid = r_tx_valid;
   assign tx_data  = r_tx_data;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with two requesters and four-digit payloads.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req;
   logic [31:0] data_in;
   logic [1:0]  grant;
   logic [1:0]  done;
   logic        busy;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(.REQ_COUNT(2), .DIGIT_COUNT(4), .APPEND_CR(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .data_in  (data_in),
      .grant    (grant),
      .done     (done),
      .busy     (busy),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Acts as requester and UART: records accepted bytes until a done pulse or the budget runs out.
   task automatic capture_msg(input int bp, input int keep,
                              output logic [63:0] bytes_o, output int n_o,
                              output logic [1:0] g_o, output logic [1:0] d_o,
                              output int to_o, output int multi_o, output int unst_o);
      int cyc;
      int phase;
      logic held;
      logic [7:0] held_data;
      cyc = 0; phase = 0; held = 1'b0; held_data = 8'h00;
      bytes_o = 64'h0; n_o = 0; g_o = 2'b00; d_o = 2'b00; to_o = 0; multi_o = 0; unst_o = 0;
      while (d_o == 2'b00 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (grant == 2'b11) multi_o++;
         if (held && (tx_valid !== 1'b1 || tx_data !== held_data)) unst_o++;
         if (done != 2'b00) begin
            d_o = done;
            held = 1'b0;
            if (keep == 0) req = req & ~done;
         end else begin
            if (bp != 0) tx_ready = (phase % 4 == 0);
            else tx_ready = 1'b1;
            phase++;
            if (tx_valid && tx_ready) begin
               if (n_o < 8) bytes_o[n_o*8 +: 8] = tx_data;
               if (n_o == 0) g_o = grant;
               n_o++;
               held = 1'b0;
            end else if (tx_valid) begin
               held = 1'b1;
               held_data = tx_data;
            end else begin
               held = 1'b0;
            end
         end
      end
      if (d_o == 2'b00) to_o = 1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 2'b00; data_in = 32'h0; tx_ready = 1'b0;
      idle_cycles(3);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      reset = 1'b1;
      idle_cycles(2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      logic [39:0] exp;
      exp = {8'h0D, 8'h46, 8'h32, 8'h41, 8'h31};
      data_in = {16'h0000, 16'h1A2F}; req = 2'b01; tx_ready = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'b01 || busy !== 1'b1) begin failures++; $display("FAIL single_grant got=%b/%b exp=01/1", grant, busy); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp[i*8 +: 8]) begin
            failures++; $display("FAIL single_byte%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp[i*8 +: 8]);
         end
         @(negedge clk);
      end
      checks++; if (done !== 2'b01 || tx_valid !== 1'b0 || grant !== 2'b01) begin failures++; $display("FAIL single_done got=%b/%b/%b exp=01/0/01", done, tx_valid, grant); end
      req = 2'b00;
      @(negedge clk);
      checks++; if (done !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL single_after got=%b/%b/%b exp=00/00/0", done, grant, busy); end
   endtask

   task automatic test_contention();
      logic [63:0] b; int n; logic [1:0] g; logic [1:0] d; int to; int multi; int unst;
      reset = 1'b0; req = 2'b11; data_in = {16'hABCD, 16'h1234}; tx_ready = 1'b1;
      idle_cycles(2);
      reset = 1'b1;
      capture_msg(0, 0, b, n, g, d, to, multi, unst);
      checks++; if (to != 0 || g !== 2'b01 || d !== 2'b01) begin failures++; $display("FAIL contention_first got=%b/%b to=%0d exp=01/01", g, d, to); end
      checks++; if (n != 5 || b[39:0] !== 40'h0D34333231) begin failures++; $display("FAIL contention_bytes0 got=%0d/%h exp=5/0d34333231", n, b[39:0]); end
      checks++; if (multi != 0) begin failures++; $display("FAIL contention_onehot0 got=%0d exp=0", multi); end
      capture_msg(0, 0, b, n, g, d, to, multi, unst);
      checks++; if (to != 0 || g !== 2'b10 || d !== 2'b10) begin failures++; $display("FAIL contention_second got=%b/%b to=%0d exp=10/10", g, d, to); end
      checks++; if (n != 5 || b[39:0] !== 40'h0D44434241) begin failures++; $display("FAIL contention_bytes1 got=%0d/%h exp=5/0d44434241", n, b[39:0]); end
      checks++; if (multi != 0) begin failures++; $display("FAIL contention_onehot1 got=%0d exp=0", multi); end
   endtask

   task automatic test_fairness();
      logic [63:0] b; int n; logic [1:0] g; logic [1:0] d; int to; int multi; int unst;
      logic [1:0] exp_g;
      idle_cycles(2);
      req = 2'b11;
      for (int m = 0; m < 4; m++) begin
         exp_g = (m % 2 == 0) ? 2'b01 : 2'b10;
         capture_msg(0, 1, b, n, g, d, to, multi, unst);
         checks++;
         if (to != 0 || g !== exp_g || d !== exp_g || multi != 0) begin
            failures++; $display("FAIL fairness_msg%0d got=%b/%b to=%0d multi=%0d exp=%b", m, g, d, to, multi, exp_g);
         end
      end
      req = 2'b00;
      idle_cycles(3);
   endtask

   task automatic test_backpressure();
      logic [63:0] b; int n; logic [1:0] g; logic [1:0] d; int to; int multi; int unst;
      data_in = {16'h0000, 16'hBEEF}; req = 2'b01;
      capture_msg(1, 0, b, n, g, d, to, multi, unst);
      checks++; if (to != 0 || d !== 2'b01) begin failures++; $display("FAIL backpressure_done got=%b to=%0d exp=01", d, to); end
      checks++; if (n != 5 || b[39:0] !== 40'h0D46454542) begin failures++; $display("FAIL backpressure_bytes got=%0d/%h exp=5/0d46454542", n, b[39:0]); end
      checks++; if (unst != 0) begin failures++; $display("FAIL backpressure_stable got=%0d exp=0", unst); end
      tx_ready = 1'b1;
      idle_cycles(3);
   endtask

   task automatic test_reset_mid();
      logic [63:0] b; int n; logic [1:0] g; logic [1:0] d; int to; int multi; int unst;
      int seen_done;
      data_in = {16'h5A00, 16'h1A2F}; req = 2'b01; tx_ready = 1'b1;
      idle_cycles(3);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h32) begin failures++; $display("FAIL resetmid_pre got=%b/%h exp=1/32", tx_valid, tx_data); end
      reset = 1'b0;
      #1;
      checks++;
      if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         failures++; $display("FAIL resetmid_clear got=%b/%b/%b/%b/%h exp=00/00/0/0/00", grant, done, busy, tx_valid, tx_data);
      end
      req = 2'b10;
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done != 2'b00) seen_done++;
      end
      checks++; if (seen_done != 0) begin failures++; $display("FAIL resetmid_nodone got=%0d exp=0", seen_done); end
      reset = 1'b1;
      capture_msg(0, 0, b, n, g, d, to, multi, unst);
      checks++; if (to != 0 || g !== 2'b10 || d !== 2'b10) begin failures++; $display("FAIL resetmid_serve got=%b/%b to=%0d exp=10/10", g, d, to); end
      checks++; if (n != 5 || b[39:0] !== 40'h0D30304135) begin failures++; $display("FAIL resetmid_bytes got=%0d/%h exp=5/0d30304135", n, b[39:0]); end
      idle_cycles(2);
   endtask

   task automatic test_payload_latch();
      logic [63:0] b; int n; logic [1:0] g; logic [1:0] d; int to; int multi; int unst;
      data_in = 32'h0000_0000; req = 2'b01; tx_ready = 1'b1;
      fork
         capture_msg(0, 0, b, n, g, d, to, multi, unst);
         begin
            @(negedge clk);
            data_in[15:0] = 16'hFFFF;
         end
      join
      checks++; if (to != 0 || g !== 2'b01 || d !== 2'b01) begin failures++; $display("FAIL payload_done got=%b/%b to=%0d exp=01/01", g, d, to); end
      checks++; if (n != 5 || b[39:0] !== 40'h0D30303030) begin failures++; $display("FAIL payload_bytes got=%0d/%h exp=5/0d30303030", n, b[39:0]); end
      idle_cycles(2);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      test_payload_latch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
